uart_alu_frame_ctrl: RTL and testbench
======================================

// Module: uart_alu_frame_ctrl
// PURPOSE
//  Consumes bytes from the UART receiver (rx_done_tick + rx_data) and assembles 3-byte frames: operand A, operand B, opcode.
//  Drives a combinational ALU with the assembled fields.
//  Hands the ALU result to the UART transmitter as a single byte, then waits for transmit completion before the next frame.
//  Includes an inter-byte timeout so a partial frame cannot wedge the link.
// PARAMETERS
//  DBIT     8        data/operand width, equal to the receiver's data width
//  OPBIT    6        opcode width; opcode = rx_data[OPBIT-1:0]
//  TOUT_W   20       timeout counter width
//  TOUT_CYC 1000000  clk cycles allowed between bytes of one frame (>=2, < 2**TOUT_W)
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high reset
//  rx_done_tick  in   1      1-cycle pulse: rx_data holds a new byte
//  rx_data       in   DBIT   received byte
//  alu_result    in   DBIT   combinational ALU output for (alu_a, alu_b, alu_op)
//  tx_done_tick  in   1      1-cycle pulse: transmitter finished the byte
//  alu_a         out  DBIT   operand A register
//  alu_b         out  DBIT   operand B register
//  alu_op        out  OPBIT  opcode register
//  tx_start      out  1      1-cycle pulse requesting transmission of tx_data
//  tx_data       out  DBIT   result byte, registered
//  busy          out  1      high while in S_EXEC or S_TX (combinational from state)
//  drop_err      out  1      1-cycle pulse: a byte was discarded
//  tout_err      out  1      1-cycle pulse: partial frame abandoned on timeout
// BEHAVIOUR
//  Reset (sync, reset=1 at rising edge):
//   - state=S_A; all outputs and the timeout counter = 0.
//   - Reset mid-frame or mid-TX abandons the operation; no tx_start is issued afterwards.
//  States:
//   - S_A: on rx_done_tick, alu_a<=rx_data, cnt<=0 -> S_B.
//   - S_B: on rx_done_tick, alu_b<=rx_data, cnt<=0 -> S_OP.
//   - S_OP: on rx_done_tick, alu_op<=rx_data[OPBIT-1:0] -> S_EXEC.
//   - S_EXEC: tx_data<=alu_result, tx_start<=1 for exactly one cycle -> S_TX.
//   - S_TX: stay until tx_done_tick -> S_A.
//  Latency: opcode rx_done_tick in cycle N gives alu_op valid at N+1, tx_start=1 and tx_data valid at N+2.
//  tx_data holds its value until the next S_EXEC.
//  Timeout (S_B, S_OP only):
//   - cnt increments each cycle without rx_done_tick.
//   - When cnt==TOUT_CYC-1 and no rx_done_tick: -> S_A, cnt<=0, tout_err pulse.
//   - rx_done_tick in the same cycle as expiry wins: the byte is accepted and no timeout occurs.
//   - cnt is held at 0 in S_A, S_EXEC and S_TX.
//   - alu_a/alu_b retain their stale values after a timeout.
//  Discard:
//   - rx_done_tick in S_EXEC or S_TX: byte dropped, drop_err pulse next cycle, state unchanged.
//   - tx_done_tick outside S_TX is ignored.
//  The ALU is external and combinational. The block adds no arithmetic; widths pass through unchanged.
//  drop_err and tout_err are registered 1-cycle pulses, never sticky.
// TESTING
//  1. Bytes 0x05, 0x03, 0x20 (ALU model ADD) -> tx_start pulse 2 cycles after the 3rd tick, tx_data=0x08, busy=1 until tx_done_tick.
//  2. Byte 0x11, then idle TOUT_CYC cycles -> tout_err pulse, state S_A; next frame 0x01, 0x02, 0x20 -> tx_data=0x03.
//  3. Byte arrives while busy (S_TX) -> drop_err 1 cycle; after tx_done_tick the next 3 bytes form a fresh frame correctly.
//  4. reset asserted after 2 bytes -> all outputs 0, state S_A; following full frame processed normally.
//  5. rx_done_tick exactly at timeout expiry in S_B -> byte accepted as B, no tout_err.
//  6. Two back-to-back frames, second A byte arriving 1 cycle after tx_done_tick -> both results transmitted, no drops.

Source files
------------

// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller between a UART receiver/transmitter pair and an external
// combinational ALU. It collects operand A, operand B and an opcode, then sends
// the ALU result back as a single byte. An inter-byte timeout drops partial frames.
module uart_alu_frame_ctrl #(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned OPBIT    = 6,
  parameter int unsigned TOUT_W   = 20,
  parameter int unsigned TOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done_tick,
  input  logic [DBIT-1:0]  rx_data,
  input  logic [DBIT-1:0]  alu_result,
  input  logic             tx_done_tick,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [OPBIT-1:0] alu_op,
  output logic             tx_start,
  output logic [DBIT-1:0]  tx_data,
  output logic             busy,
  output logic             drop_err,
  output logic             tout_err
);

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_TX} state_t;

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CYC - 1);

  state_t            state, state_next;
  logic [TOUT_W-1:0] cnt, cnt_next;
  logic              load_a, load_b, load_op, exec, drop, tout;

  // Next-state, timeout counter and per-cycle control decode.
  // The counter defaults to 0 so it is cleared whenever a byte is accepted
  // or the state is outside S_B/S_OP; it only advances while waiting.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    exec       = 1'b0;
    drop       = 1'b0;
    tout       = 1'b0;
    case (state)
      S_A: begin
        if (rx_done_tick) begin
          load_a     = 1'b1;
          state_next = S_B;
        end
      end
      S_B: begin
        if (rx_done_tick) begin
          load_b     = 1'b1;
          state_next = S_OP;
        end else if (cnt == TOUT_LAST) begin
          tout       = 1'b1;
          state_next = S_A;
        end else begin
          cnt_next = cnt + TOUT_W'(1);
        end
      end
      S_OP: begin
        if (rx_done_tick) begin
          load_op    = 1'b1;
          state_next = S_EXEC;
        end else if (cnt == TOUT_LAST) begin
          tout       = 1'b1;
          state_next = S_A;
        end else begin
          cnt_next = cnt + TOUT_W'(1);
        end
      end
      S_EXEC: begin
        exec       = 1'b1;
        drop       = rx_done_tick;
        state_next = S_TX;
      end
      S_TX: begin
        drop = rx_done_tick;
        if (tx_done_tick) state_next = S_A;
      end
      default: state_next = S_A;
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_A;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Operand/opcode capture, result register and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      drop_err <= 1'b0;
      tout_err <= 1'b0;
    end else begin
      if (load_a)  alu_a   <= rx_data;
      if (load_b)  alu_b   <= rx_data;
      if (load_op) alu_op  <= rx_data[OPBIT-1:0];
      if (exec)    tx_data <= alu_result;
      tx_start <= exec;
      drop_err <= drop;
      tout_err <= tout;
    end
  end

  // Busy is decoded straight from the state register.
  always_comb begin
    busy = (state == S_EXEC) || (state == S_TX);
  end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Directed self-checking bench for uart_alu_frame_ctrl with a small ALU model
// and a shortened timeout.
module tb_uart_alu_frame_ctrl;

  localparam int unsigned DBIT     = 8;
  localparam int unsigned OPBIT    = 6;
  localparam int unsigned TOUT_W   = 4;
  localparam int unsigned TOUT_CYC = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_done_tick;
  logic [DBIT-1:0]  rx_data;
  logic [DBIT-1:0]  alu_result;
  logic             tx_done_tick;
  logic [DBIT-1:0]  alu_a;
  logic [DBIT-1:0]  alu_b;
  logic [OPBIT-1:0] alu_op;
  logic             tx_start;
  logic [DBIT-1:0]  tx_data;
  logic             busy;
  logic             drop_err;
  logic             tout_err;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int drop_cnt = 0;
  int tout_cnt = 0;

  uart_alu_frame_ctrl #(
    .DBIT(DBIT), .OPBIT(OPBIT), .TOUT_W(TOUT_W), .TOUT_CYC(TOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .alu_result(alu_result), .tx_done_tick(tx_done_tick), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .drop_err(drop_err), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  // External ALU model: ADD/SUB/AND/OR/XOR on MIPS-style function codes.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      6'h26:   alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_start) tx_cnt++;
    if (drop_err) drop_cnt++;
    if (tout_err) tout_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  task automatic wait_tx_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data} !== '0) begin
      errors++;
      $display("FAIL reset_regs got a=%h b=%h op=%h tx=%h want all 0", alu_a, alu_b, alu_op, tx_data);
    end
    checks++;
    if ({tx_start, busy, drop_err, tout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {tx_start, busy, drop_err, tout_err});
    end
  endtask

  task automatic test_basic_add();
    bit ok;
    send_frame(8'h05, 8'h03, 8'h20);
    checks++;
    if (alu_op !== 6'h20 || tx_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_n1 got op=%h start=%b busy=%b want 20 0 1", alu_op, tx_start, busy);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
      errors++;
      $display("FAIL add_n2 got start=%b tx=%h want 1 08", tx_start, tx_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL add_hold got start=%b busy=%b want 0 1", tx_start, busy);
    end
    pulse_tx_done();
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'h08 || tx_cnt !== 1) begin
      errors++;
      $display("FAIL add_done got busy=%b tx=%h txcnt=%0d want 0 08 1", busy, tx_data, tx_cnt);
    end
    ok = 1'b1;
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    send_byte(8'h11);
    early = 1'b0;
    for (int i = 0; i < int'(TOUT_CYC) - 1; i++) begin
      @(negedge clk);
      if (tout_err) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL tout_early got 1 want 0");
    end
    @(negedge clk);
    checks++;
    if (tout_err !== 1'b1 || busy !== 1'b0 || alu_a !== 8'h11) begin
      errors++;
      $display("FAIL tout_fire got tout=%b busy=%b a=%h want 1 0 11", tout_err, busy, alu_a);
    end
    @(negedge clk);
    checks++;
    if (tout_err !== 1'b0) begin
      errors++;
      $display("FAIL tout_pulse got %b want 0", tout_err);
    end
    send_frame(8'h01, 8'h02, 8'h20);
    wait_tx_start(ok);
    checks++;
    if (!ok || tx_data !== 8'h03) begin
      errors++;
      $display("FAIL tout_next got ok=%b tx=%h want 1 03", ok, tx_data);
    end
    pulse_tx_done();
  endtask

  task automatic test_drop();
    bit ok;
    send_frame(8'h07, 8'h02, 8'h22);
    wait_tx_start(ok);
    checks++;
    if (!ok || tx_data !== 8'h05) begin
      errors++;
      $display("FAIL drop_sub got ok=%b tx=%h want 1 05", ok, tx_data);
    end
    send_byte(8'h99);
    checks++;
    if (drop_err !== 1'b1 || busy !== 1'b1 || alu_a !== 8'h07) begin
      errors++;
      $display("FAIL drop_pulse got drop=%b busy=%b a=%h want 1 1 07", drop_err, busy, alu_a);
    end
    @(negedge clk);
    checks++;
    if (drop_err !== 1'b0 || tx_data !== 8'h05) begin
      errors++;
      $display("FAIL drop_clear got drop=%b tx=%h want 0 05", drop_err, tx_data);
    end
    pulse_tx_done();
    send_frame(8'h0F, 8'h3C, 8'h24);
    wait_tx_start(ok);
    checks++;
    if (!ok || alu_a !== 8'h0F || alu_b !== 8'h3C || tx_data !== 8'h0C) begin
      errors++;
      $display("FAIL drop_fresh got ok=%b a=%h b=%h tx=%h want 1 0f 3c 0c", ok, alu_a, alu_b, tx_data);
    end
    pulse_tx_done();
  endtask

  task automatic test_midframe_reset();
    bit ok;
    int tx_before;
    send_byte(8'h40);
    send_byte(8'h41);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data} !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got a=%h b=%h op=%h tx=%h busy=%b want 0", alu_a, alu_b, alu_op, tx_data, busy);
    end
    tx_before = tx_cnt;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_cnt !== tx_before || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet got txcnt=%0d busy=%b want %0d 0", tx_cnt, busy, tx_before);
    end
    send_frame(8'h09, 8'h04, 8'h26);
    wait_tx_start(ok);
    checks++;
    if (!ok || tx_data !== 8'h0D) begin
      errors++;
      $display("FAIL rst_after got ok=%b tx=%h want 1 0d", ok, tx_data);
    end
    pulse_tx_done();
  endtask

  task automatic test_tick_at_expiry();
    bit ok;
    int tout_before;
    tout_before = tout_cnt;
    send_byte(8'h30);
    repeat (TOUT_CYC - 1) @(negedge clk);
    rx_data = 8'h12;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    checks++;
    if (tout_err !== 1'b0 || alu_b !== 8'h12 || tout_cnt !== tout_before) begin
      errors++;
      $display("FAIL expiry_b got tout=%b b=%h toutcnt=%0d want 0 12 %0d", tout_err, alu_b, tout_cnt, tout_before);
    end
    send_byte(8'h20);
    wait_tx_start(ok);
    checks++;
    if (!ok || tx_data !== 8'h42) begin
      errors++;
      $display("FAIL expiry_res got ok=%b tx=%h want 1 42", ok, tx_data);
    end
    pulse_tx_done();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int tx_before;
    int drop_before;
    tx_before = tx_cnt;
    drop_before = drop_cnt;
    send_frame(8'h80, 8'h80, 8'h20);
    wait_tx_start(ok);
    checks++;
    if (!ok || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL b2b_first got ok=%b tx=%h want 1 00", ok, tx_data);
    end
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    rx_data = 8'hAA;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    send_byte(8'h55);
    send_byte(8'hE5);
    checks++;
    if (alu_a !== 8'hAA || alu_op !== 6'h25) begin
      errors++;
      $display("FAIL b2b_fields got a=%h op=%h want aa 25", alu_a, alu_op);
    end
    wait_tx_start(ok);
    checks++;
    if (!ok || tx_data !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_second got ok=%b tx=%h want 1 ff", ok, tx_data);
    end
    pulse_tx_done();
    checks++;
    if (tx_cnt - tx_before !== 2 || drop_cnt !== drop_before || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_counts got tx=%0d drops=%0d busy=%b want 2 0 0", tx_cnt - tx_before, drop_cnt - drop_before, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_done_tick = 1'b0;
    rx_data = '0;
    tx_done_tick = 1'b0;
    test_reset();
    test_basic_add();
    test_timeout();
    test_drop();
    test_midframe_reset();
    test_tick_at_expiry();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
